// File: rtl/router_wb.sv
// router_wb: result write-back router.
// Selects the adder or multiplier result, optionally halves or negates it
// with saturation, and queues {value, destination} in a small FIFO that
// drains to the register-file write port.
//
// Handshake (both ports): a transfer happens on a rising edge where valid
// and ready are both 1. The producer holds its payload stable while valid is
// high and ready is low. in_ready depends only on registered occupancy and
// never on wr_ready, so a full FIFO refuses input even while it is popping.
module router_wb #(
    parameter int W     = 24,
    parameter int DEPTH = 4,
    parameter int AW    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             SUM,
    input  logic [W-1:0]             PROD,
    input  logic [1:0]               sel_W,
    input  logic                     inv_W,
    input  logic [AW-1:0]            dst,
    output logic                     wr_valid,
    input  logic                     wr_ready,
    output logic [W-1:0]             wr_data,
    output logic [AW-1:0]            wr_addr,
    output logic                     msb_W,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    input  logic                     clr_ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [W-1:0]  MIN_V = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  MAX_V = {1'b0, {(W-1){1'b1}}};

    logic [W-1:0]  mem_data [DEPTH];
    logic [AW-1:0] mem_addr [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [W-1:0]  sel_v;
    logic [W-1:0]  r_val;
    logic          sat;
    logic          push;
    logic          pop;

    // Source select and negate; only negating the most negative value saturates.
    always_comb begin
        sel_v = '0;
        r_val = '0;
        sat   = 1'b0;
        case (sel_W)
            2'b00:   sel_v = SUM;
            2'b01:   sel_v = PROD;
            2'b10:   sel_v = $unsigned($signed(SUM) >>> 1);
            default: sel_v = '0;
        endcase
        if (inv_W) begin
            if (sel_v == MIN_V) begin
                r_val = MAX_V;
                sat   = 1'b1;
            end else begin
                r_val = (~sel_v) + W'(1);
            end
        end else begin
            r_val = sel_v;
        end
    end

    assign in_ready = (count < FULL);
    assign wr_valid = (count != '0);
    assign push     = in_valid && in_ready;
    assign pop      = wr_valid && wr_ready;
    assign wr_data  = mem_data[rptr];
    assign wr_addr  = mem_addr[rptr];
    assign msb_W    = wr_data[W-1];

    // Entry storage; cleared on reset so the head is never X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_addr[i] <= '0;
            end
        end else if (push) begin
            mem_data[wptr] <= r_val;
            mem_addr[wptr] <= dst;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a saturating push beats a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (push && sat) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: doc/router_wb.md
# router_wb

Result write-back router for the Kalman datapath; the return path to the operand router. Takes 24-bit two's-complement results from the adder (SUM) and multiplier (PROD) and selects one. It can negate or halve the result, saturating on overflow. Results are buffered in a 4-entry FIFO and drained to the register-file write port through a valid/ready handshake, with a destination address and sign flag.

## Interface
- W, 24, datapath word width (two's complement)
- DEPTH, 4, FIFO entries (power of two)
- AW, 3, destination register address width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  result pending from arithmetic unit
- in_ready  out  1  router can accept this cycle
- SUM  in  W  adder result
- PROD  in  W  multiplier result (already truncated to W)
- sel_W  in  2  source select: 00 SUM, 01 PROD, 10 SUM>>>1, 11 zero
- inv_W  in  1  negate selected value
- dst  in  AW  destination register address
- wr_valid  out  1  FIFO head valid
- wr_ready  in  1  register file accepts head
- wr_data  out  W  head data
- wr_addr  out  AW  head address
- msb_W  out  1  wr_data[W-1]
- count  out  log2(DEPTH)+1  occupancy
- ovf  out  1  sticky saturation flag
- clr_ovf  in  1  clears ovf

## Operation
- Value path (combinational, per accepted input):
  - v = mux(sel_W). SUM>>>1 is an arithmetic shift that preserves the sign.
  - If inv_W, r = -v; otherwise r = v.
  - -(-2^(W-1)) saturates to 2^(W-1)-1 (0x7FFFFF) and sets sat=1. No other case saturates.
- Push:
  - Occurs when in_valid && in_ready.
  - Writes {r, dst} at wptr, then increments wptr modulo DEPTH.
  - If sat=1, sets ovf at the same edge.
- Pop:
  - Occurs when wr_valid && wr_ready.
  - Increments rptr modulo DEPTH.
- in_ready = (count < DEPTH). It is registered-state-derived and never depends combinationally on wr_ready: a full FIFO refuses input even when popping that cycle.
- wr_valid = (count != 0). wr_data, wr_addr and msb_W always reflect the entry at rptr. They are don't-care while wr_valid=0 but must not be X after reset.
- Occupancy:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop together: count is unchanged and both pointers advance.
- ovf:
  - clr_ovf clears ovf.
  - A saturating push in the same cycle as clr_ovf wins, so ovf=1.
- Handshake rules:
  - Once wr_valid=1, wr_data/wr_addr are held until popped.
  - in_valid with in_ready=0 is ignored. The upstream block holds the request.

## Timing
- Reset (async assert, sync release) values:
  - wptr=rptr=0, count=0, ovf=0.
  - wr_valid=0, in_ready=1.
  - wr_data=0, wr_addr=0, msb_W=0; all storage cleared.
- Latency: an input accepted at edge N appears on wr_data with wr_valid=1 after edge N. It is poppable in cycle N+1, giving 1-cycle accept-to-visible latency with no bypass.
- Throughput: 1 result/cycle sustained when wr_ready=1 continuously.
- Pointer wrap: from DEPTH-1 to 0 with no bubble.
- Reset mid-operation: all queued entries are discarded immediately and outputs go to reset values asynchronously. A handshake in flight during the reset cycle is lost.

## Test plan
- Reset, then push SUM=0x000010 (sel 00, inv 0, dst 3) with wr_ready=1:
  - wr_valid=1, wr_data=0x000010, wr_addr=3, msb_W=0 one cycle later.
  - count returns to 0 next cycle.
- Push PROD=0x000005 with inv_W=1: wr_data=0xFFFFFB, msb_W=1, ovf=0.
- Push SUM=0x800000 with sel 10 then sel 00+inv:
  - First: 0xC00000.
  - Second: 0x7FFFFF and ovf=1.
  - clr_ovf clears ovf. clr_ovf coincident with another saturating push leaves ovf=1.
- Back-pressure: wr_ready=0, push 5 results back-to-back:
  - The first 4 are accepted (count=4); in_ready drops after the 4th push.
  - The 5th is held by the source. wr_valid=1 throughout.
  - Then wr_ready=1 drains all in order with correct addresses, including after pointer wrap.
- Simultaneous push/pop at count=2 for 10 cycles: count stays 2, data order preserved. At count=4 with wr_ready=1 and in_valid=1: no push that cycle, count=3 next.
- Assert rst while count=3 and mid-handshake: count=0, wr_valid=0, ovf=0 immediately. The first push after release appears with wr_addr as pushed.
